// File: rtl/mcu_bus_fabric.sv
// mcu_bus_fabric: CPU-to-peripheral fabric with programmable address windows,
// per-window wait states, registered read data and ready/error handshake.
module mcu_bus_fabric #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int N_SLV  = 4,
    parameter logic [N_SLV*ADDR_W-1:0] BASE = {16'h8000, 16'h0400, 16'h0200, 16'h0000},
    parameter logic [N_SLV*ADDR_W-1:0] MASK = {16'h8000, 16'hFC00, 16'hFFF0, 16'hFE00},
    parameter logic [N_SLV*4-1:0]      WAIT = {4'd2, 4'd3, 4'd1, 4'd0}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W-1:0]       m_wdata,
    input  logic                    m_rden,
    input  logic                    m_wren,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [N_SLV-1:0]        s_ce,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    output logic                    s_rden,
    output logic                    s_wren,
    input  logic [N_SLV*DATA_W-1:0] s_rdata
);
    localparam int SW = N_SLV > 1 ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [SW-1:0]       slot_q;
    logic                err_q;
    logic [DATA_W-1:0]   m_rdata_q;
    logic                m_ready_q;
    logic                m_err_q;
    logic [N_SLV-1:0]    s_ce_q;
    logic [ADDR_W-1:0]   s_addr_q;
    logic [DATA_W-1:0]   s_wdata_q;
    logic                s_rden_q;
    logic                s_wren_q;

    logic [N_SLV-1:0]    hit;
    logic [N_SLV-1:0]    sel_d;
    logic [SW-1:0]       slot_d;
    logic [3:0]          wait_d;
    logic [DATA_W-1:0]   rdata_d;

    for (genvar g = 0; g < N_SLV; g++) begin : g_dec
        assign hit[g] = (m_addr & MASK[g*ADDR_W +: ADDR_W]) == BASE[g*ADDR_W +: ADDR_W];
    end

    // Lowest-index hit wins: isolate the lowest set bit of the hit vector.
    assign sel_d   = hit & (~hit + 1'b1);
    assign rdata_d = s_rdata[slot_q*DATA_W +: DATA_W];

    always_comb begin
        slot_d = '0;
        wait_d = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (hit[i]) begin
                slot_d = SW'(i);
                wait_d = WAIT[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            err_q     <= 1'b0;
            m_rdata_q <= '0;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
            s_ce_q    <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_rden_q  <= 1'b0;
            s_wren_q  <= 1'b0;
        end else begin
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_rden || m_wren) begin
                        if ((m_rden && m_wren) || hit == '0) begin
                            err_q     <= 1'b1;
                            m_rdata_q <= '0;
                            state_q   <= DONE;
                        end else begin
                            err_q     <= 1'b0;
                            s_addr_q  <= m_addr;
                            s_wdata_q <= m_wdata;
                            s_ce_q    <= sel_d;
                            s_rden_q  <= m_rden;
                            s_wren_q  <= m_wren;
                            slot_q    <= slot_d;
                            cnt_q     <= wait_d;
                            state_q   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (s_rden_q) m_rdata_q <= rdata_d;
                        s_ce_q   <= '0;
                        s_rden_q <= 1'b0;
                        s_wren_q <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    m_ready_q <= 1'b1;
                    m_err_q   <= err_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_ready = m_ready_q;
    assign m_err   = m_err_q;
    assign s_ce    = s_ce_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign s_rden  = s_rden_q;
    assign s_wren  = s_wren_q;
endmodule

// File: tb/tb_mcu_bus_fabric.sv
// tb_mcu_bus_fabric: randomized transactions against a transaction-level model
// of the fabric (decode, latency, result), plus directed literal checks.
module tb_mcu_bus_fabric;
    localparam int N = 4;
    localparam logic [15:0] BASES [N] = '{16'h0000, 16'h0200, 16'h0400, 16'h8000};
    localparam logic [15:0] MASKS [N] = '{16'hFE00, 16'hFFF0, 16'hFC00, 16'h8000};
    localparam int          WTS   [N] = '{0, 1, 3, 2};

    logic        clk = 0;
    logic        rst = 0;
    logic [15:0] m_addr = 0;
    logic [7:0]  m_wdata = 0;
    logic        m_rden = 0;
    logic        m_wren = 0;
    logic [31:0] s_rdata = 0;
    logic [7:0]  m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [3:0]  s_ce;
    logic [15:0] s_addr;
    logic [7:0]  s_wdata;
    logic        s_rden;
    logic        s_wren;

    mcu_bus_fabric dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rden(m_rden), .m_wren(m_wren), .m_rdata(m_rdata), .m_ready(m_ready),
        .m_err(m_err), .s_ce(s_ce), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rden(s_rden), .s_wren(s_wren), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Transaction model: a request is taken at the first edge the fabric is free;
    // it completes lat edges later and the fabric is free again one edge after that.
    int          cyc = 0;
    bit          act = 0;
    int          e_cyc, lat, slot;
    bit          flt, mrd;
    logic [15:0] maddr;
    logic [7:0]  mwd, res;
    logic [7:0]  last = 0;
    bit          acc, rdy;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            act = 0;
        end else begin
            if (act && cyc > e_cyc + lat) act = 0;
            if (!act && (m_rden || m_wren)) begin
                slot = -1;
                for (int i = N - 1; i >= 0; i--)
                    if ((m_addr & MASKS[i]) == BASES[i]) slot = i;
                flt   = (m_rden && m_wren) || slot < 0;
                act   = 1;
                e_cyc = cyc;
                mrd   = m_rden;
                maddr = m_addr;
                mwd   = m_wdata;
                lat   = flt ? 1 : WTS[slot] + 2;
                res   = flt ? 8'h00 : (m_rden ? s_rdata[slot*8 +: 8] : last);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            last = 0;
            chk("rst_m_ready", m_ready, 0);
            chk("rst_m_err", m_err, 0);
            chk("rst_m_rdata", m_rdata, 0);
            chk("rst_s_ce", s_ce, 0);
            chk("rst_s_strobes", {s_rden, s_wren}, 0);
            chk("rst_s_addr", s_addr, 0);
            chk("rst_s_wdata", s_wdata, 0);
        end else begin
            acc = act && !flt && cyc >= e_cyc && cyc <= e_cyc + lat - 2;
            rdy = act && cyc == e_cyc + lat;
            chk("s_ce", s_ce, acc ? (32'd1 << slot) : 32'd0);
            chk("s_rden", s_rden, acc && mrd);
            chk("s_wren", s_wren, acc && !mrd);
            if (acc) begin
                chk("s_addr", s_addr, maddr);
                chk("s_wdata", s_wdata, mwd);
            end
            chk("m_ready", m_ready, rdy);
            chk("m_err", m_err, rdy && flt);
            if (rdy) begin
                chk("m_rdata_done", m_rdata, res);
                last = res;
            end else if (!act) begin
                chk("m_rdata_hold", m_rdata, last);
            end
        end
    end

    task automatic xfer(input logic [15:0] a, input logic [7:0] wd, input bit rd, input bit wr,
                        input logic [31:0] srd, output int l, output logic [7:0] d, output logic e);
        int ic;
        m_addr  = a;
        m_wdata = wd;
        m_rden  = rd;
        m_wren  = wr;
        s_rdata = srd;
        ic = cyc;
        l = -1;
        d = 0;
        e = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (m_ready) begin
                l = cyc - ic - 1;
                d = m_rdata;
                e = m_err;
                break;
            end
        end
        if (l < 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: no m_ready for addr %0h", a);
        end
    endtask

    task automatic idle(input int n);
        m_rden = 0;
        m_wren = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          l;
        logic [7:0]  d;
        logic        e;
        logic [15:0] a;
        bit          saw;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        idle(2);

        xfer(16'h0005, 8'h00, 1, 0, 32'h5A5A5AA5, l, d, e);
        chk("rd0_lat", l, 2); chk("rd0_data", d, 8'hA5); chk("rd0_err", e, 0);
        idle(1);
        xfer(16'h0203, 8'h55, 0, 1, 32'h11223344, l, d, e);
        chk("wr1_lat", l, 3); chk("wr1_rdata_kept", d, 8'hA5); chk("wr1_err", e, 0);
        idle(1);
        xfer(16'h7000, 8'h00, 1, 0, 32'hFFFFFFFF, l, d, e);
        chk("unmap_lat", l, 1); chk("unmap_data", d, 0); chk("unmap_err", e, 1);
        idle(2);
        xfer(16'h0000, 8'h12, 1, 1, 32'hFFFFFFFF, l, d, e);
        chk("both_lat", l, 1); chk("both_err", e, 1);
        idle(1);
        xfer(16'h0400, 8'h00, 1, 0, 32'hC33C0000, l, d, e);
        chk("b2b1_lat", l, 5); chk("b2b1_data", d, 8'h3C);
        xfer(16'h8001, 8'h00, 1, 0, 32'hC33C0000, l, d, e);
        chk("b2b2_lat", l, 4); chk("b2b2_data", d, 8'hC3); chk("b2b2_err", e, 0);
        idle(2);

        repeat (300) begin
            case ($urandom % 10)
                0, 1, 2: a = 16'($urandom & 32'h01FF);
                3:       a = 16'h0200 | 16'($urandom & 32'h000F);
                4, 5:    a = 16'h0400 | 16'($urandom & 32'h03FF);
                6, 7:    a = 16'h8000 | 16'($urandom);
                default: a = 16'($urandom);
            endcase
            if ($urandom % 12 == 0) xfer(a, 8'($urandom), 1, 1, $urandom, l, d, e);
            else if ($urandom % 2 == 0) xfer(a, 8'($urandom), 1, 0, $urandom, l, d, e);
            else xfer(a, 8'($urandom), 0, 1, $urandom, l, d, e);
            if ($urandom % 2 == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Abort a slot-2 read mid-access; no completion may follow.
        m_addr  = 16'h0410;
        m_rden  = 1;
        s_rdata = 32'h00770000;
        @(posedge clk);
        #1 chk("abort_s_ce", s_ce, 4'b0100);
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("abort_m_ready", m_ready, 0);
        chk("abort_s_ce_zero", s_ce, 0);
        chk("abort_s_rden", s_rden, 0);
        chk("abort_s_addr", s_addr, 0);
        chk("abort_m_rdata", m_rdata, 0);
        m_rden = 0;
        @(posedge clk);
        #2 rst = 1;
        saw = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (m_ready) saw = 1;
        end
        chk("abort_no_ready", saw, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
